mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core.
- Accepts one operation per start pulse from the EX stage and latches its operands.
- Holds busy high for a fixed latency so hazard logic can stall later MD instructions, then commits the result to HI/LO.
- Also executes single-cycle mthi/mtlo writes.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu; legal range 1..15.
- DIV_CYCLES, 10: busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to perform md_op on A/B
- md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (no-op)
- A  input  32  rs operand (dividend / multiplicand / mthi-mtlo data)
- B  input  32  rt operand (divisor / multiplier)
- busy  output  1  high while a mult/div is in flight
- hi  output  32  current HI register
- lo  output  32  current LO register

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE, counter=0, busy=0, hi=0, lo=0. Reset overrides start in the same cycle. Reset mid-operation aborts the operation; HI/LO read 0 on the next cycle.
- States:
  - IDLE, busy=0.
  - BUSY, busy=1. busy is a registered output decoded from state.
- IDLE with start=1 and md_op in 0..3:
  - Latch the operation result into internal res_hi/res_lo at that edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY.
  - busy rises on the cycle after the start edge.
- BUSY: counter decrements each edge. On the edge where counter==1:
  - Commit res_hi/res_lo to hi/lo.
  - Return to IDLE.
  - busy is high for exactly N cycles; the new HI/LO values are visible in the same cycle busy falls.
- IDLE with start=1 and md_op=4 (mthi): hi<=A next edge. md_op=5 (mtlo): lo<=A next edge. No busy; lo/hi respectively unchanged.
- start with md_op 6/7: no effect.
- start while BUSY: ignored entirely; the operation in flight, counter, HI and LO are unaffected. Hazard logic must stall instead. The bench checks that start during BUSY is dropped.
- Arithmetic:
  - mult: {hi,lo} = signed(A) * signed(B), full 64-bit two's complement.
  - multu: unsigned 64-bit product.
  - div: lo = signed quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- Divide by zero (div/divu with B==0): the full busy period still occurs; hi/lo are left unchanged at commit.
- hi/lo outputs are direct register outputs. No combinational path from inputs to outputs.
- Operands are captured at start; changes on A/B during BUSY do not affect the result.

Test Plan:
- Reset, then start mult A=0xFFFFFFFD B=0x00000005:
  - busy=1 for exactly 5 cycles starting the cycle after start.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - hi/lo remain 0 throughout the busy window.
- multu A=B=0xFFFFFFFF: after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
- div A=0xFFFFFFF9 (-7) B=2:
  - busy for 10 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu with the same operands yields lo=0x7FFFFFFC, hi=0x00000001.
- mthi A=0x12345678 from IDLE: hi=0x12345678 next cycle, busy stays 0, lo unchanged.
- Divide by zero: mtlo A=0xAAAA5555, then div A=7 B=0:
  - busy for 10 cycles.
  - lo stays 0xAAAA5555 and hi is unchanged afterwards.
- Robustness:
  - Start div; in busy cycle 3 pulse start mult A=2 B=3 and mthi A=1. Both are ignored, and only the div result appears.
  - Separately, assert reset in busy cycle 4 of a mult. Next cycle busy=0, hi=lo=0, and no commit occurs later.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer that owns the HI/LO pair. The result is latched at start,
// busy is held for a fixed latency, and then the result is committed.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  // Unsigned divide returning {remainder, quotient}; the divisor is never zero here.
  function automatic logic [63:0] udivmod(input logic [31:0] n, input logic [31:0] d);
    logic [31:0] quo;
    logic [31:0] rem;
    quo = n / d;
    rem = n % d;
    return {rem, quo};
  endfunction

  // Two's complement negate, used to move between signed values and magnitudes.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        res_we_q, res_we_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  logic signed [63:0] prod_s;
  logic [63:0]        produ_s;
  logic               a_neg_s, b_neg_s, b_zero_s;
  logic [31:0]        a_mag_s, b_mag_s, b_safe_s, bu_safe_s;
  logic [63:0]        sdm_s, udm_s;
  logic [31:0]        op_hi_s, op_lo_s;
  logic               op_we_s;

  // Compute the result of the requested operation directly from the live operands.
  always_comb begin
    prod_s    = $signed(A) * $signed(B);
    produ_s   = {32'd0, A} * {32'd0, B};
    a_neg_s   = A[31];
    b_neg_s   = B[31];
    b_zero_s  = (B == 32'd0);
    a_mag_s   = a_neg_s ? neg32(A) : A;
    b_mag_s   = b_neg_s ? neg32(B) : B;
    b_safe_s  = b_zero_s ? 32'd1 : b_mag_s;
    bu_safe_s = b_zero_s ? 32'd1 : B;
    sdm_s     = udivmod(a_mag_s, b_safe_s);
    udm_s     = udivmod(A, bu_safe_s);
    op_hi_s   = 32'd0;
    op_lo_s   = 32'd0;
    op_we_s   = 1'b0;
    case (md_op)
      OP_MULT: begin
        op_hi_s = prod_s[63:32];
        op_lo_s = prod_s[31:0];
        op_we_s = 1'b1;
      end
      OP_MULTU: begin
        op_hi_s = produ_s[63:32];
        op_lo_s = produ_s[31:0];
        op_we_s = 1'b1;
      end
      OP_DIV: begin
        // Truncating divide: the quotient sign is the XOR of the operand signs, and the remainder takes the sign of the dividend.
        op_lo_s = (a_neg_s ^ b_neg_s) ? neg32(sdm_s[31:0]) : sdm_s[31:0];
        op_hi_s = a_neg_s ? neg32(sdm_s[63:32]) : sdm_s[63:32];
        op_we_s = !b_zero_s;
      end
      OP_DIVU: begin
        op_lo_s = udm_s[31:0];
        op_hi_s = udm_s[63:32];
        op_we_s = !b_zero_s;
      end
      default: begin
        op_hi_s = 32'd0;
        op_lo_s = 32'd0;
        op_we_s = 1'b0;
      end
    endcase
  end

  // Next-state logic for the sequencer, the latched result and the HI/LO pair.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_we_d = res_we_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              res_hi_d = op_hi_s;
              res_lo_d = op_lo_s;
              res_we_d = op_we_s;
              cnt_d    = MULT_LOAD;
              state_d  = ST_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              res_hi_d = op_hi_s;
              res_lo_d = op_lo_s;
              res_we_d = op_we_s;
              cnt_d    = DIV_LOAD;
              state_d  = ST_BUSY;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // A new start request is dropped here; hazard logic stalls it upstream.
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          if (res_we_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    busy_d = (state_d == ST_BUSY);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_we_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_we_q <= res_we_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: the stimulus queues the expected per-cycle busy/hi/lo values,
// and a monitor on the falling edge compares each entry in the cycle it falls due.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] hi, lo;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (e.due < cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.due, cyc);
      end else if (busy !== e.busy || hi !== e.hi || lo !== e.lo) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got busy=%b hi=%h lo=%h, want busy=%b hi=%h lo=%h",
                 e.name, cyc, busy, hi, lo, e.busy, e.hi, e.lo);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int due, input logic b, input logic [31:0] h,
                           input logic [31:0] l, input string name);
    exp_t e;
    e.due = due; e.busy = b; e.hi = h; e.lo = l; e.name = name;
    q.push_back(e);
  endtask

  // mode 0: plain; 1: ignored starts in busy cycles 3 and 4; 2: reset in busy cycle 4
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int mode);
    int n;
    int k;
    int d;
    n = (op == 3'd0 || op == 3'd1) ? 5 : ((op == 3'd2 || op == 3'd3) ? 10 : 0);
    k = cyc;
    for (int j = 1; j <= n + 2; j++) begin
      if (mode == 2) begin
        if (j <= 4) expect_at(k + j, 1'b1, cur_hi, cur_lo, name);
        else        expect_at(k + j, 1'b0, 32'd0, 32'd0, name);
      end else begin
        if (j <= n) expect_at(k + j, 1'b1, cur_hi, cur_lo, name);
        else        expect_at(k + j, 1'b0, eh, el, name);
      end
    end
    if (mode == 2) begin
      cur_hi = 32'd0;
      cur_lo = 32'd0;
    end else begin
      cur_hi = eh;
      cur_lo = el;
    end
    start = 1'b1; md_op = op; A = a; B = b;
    while (cyc < k + n + 2) begin
      tick();
      d = cyc - k;
      start = 1'b0;
      reset = 1'b0;
      A = $urandom();
      B = $urandom();
      if (mode == 1 && d == 3) begin
        start = 1'b1; md_op = 3'd0; A = 32'd2; B = 32'd3;
      end
      if (mode == 1 && d == 4) begin
        start = 1'b1; md_op = 3'd4; A = 32'd1;
      end
      if (mode == 2 && d == 4) reset = 1'b1;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
    tick();
    tick();
    expect_at(cyc, 1'b0, 32'd0, 32'd0, "reset");
    tick();
    reset = 1'b0;
    expect_at(cyc, 1'b0, 32'd0, 32'd0, "reset_release");
    tick();

    run_op("mult",      3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    run_op("multu",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op("div",       3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("divu",      3'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 0);
    run_op("mthi",      3'd4, 32'h12345678, 32'h0,        32'h12345678, 32'h7FFFFFFC, 0);
    run_op("mtlo",      3'd5, 32'hAAAA5555, 32'h0,        32'h12345678, 32'hAAAA5555, 0);
    run_op("div_by_0",  3'd2, 32'h00000007, 32'h00000000, 32'h12345678, 32'hAAAA5555, 0);
    run_op("divu_by_0", 3'd3, 32'h00000009, 32'h00000000, 32'h12345678, 32'hAAAA5555, 0);
    run_op("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    run_op("div_pos_neg", 3'd2, 32'd100,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 0);
    run_op("mult_neg_neg", 3'd0, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000, 0);
    run_op("div_ignore", 3'd2, 32'd20,      32'd3,        32'h00000002, 32'h00000006, 1);
    run_op("reserved6", 3'd6, 32'h5A5A5A5A, 32'h1,        32'h00000002, 32'h00000006, 0);
    run_op("reserved7", 3'd7, 32'h5A5A5A5A, 32'h1,        32'h00000002, 32'h00000006, 0);
    run_op("mult_reset", 3'd0, 32'd2,       32'd3,        32'h0,        32'h0,        2);
    run_op("mthi_after", 3'd4, 32'hCAFEF00D, 32'h0,       32'hCAFEF00D, 32'h00000000, 0);

    tick();
    tick();
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.due);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
